// File: rtl/spi_shift_pkg.sv
// spi_shift_pkg: shared types and helpers for the multi-lane SPI shift register
package spi_shift_pkg;
  typedef enum logic {IDLE, XFER} state_t;
  function automatic bit lanes_legal(int lanes);
    return lanes == 1 || lanes == 2 || lanes == 4;
  endfunction
  function automatic int eff_len(int len_v, int max_char, int lanes);
    int l;
    l = len_v == 0 ? max_char : len_v;
    return (l + lanes - 1) / lanes * lanes;
  endfunction
endpackage

// File: rtl/spi_lane_sel.sv
// spi_lane_sel: pointer-to-slice select, either extracting a lane group or inserting one
module spi_lane_sel #(
  parameter int W = 32,
  parameter int LANES = 1,
  parameter int PW = 6,
  parameter bit INSERT = 1'b0,
  parameter int OW = LANES
) (
  input  logic [W-1:0]     vec,
  input  logic [PW-1:0]    ptr,
  input  logic [LANES-1:0] ins,
  output logic [OW-1:0]    q
);
  if (INSERT) begin : g_ins
    // replace the LANES-wide slice starting at ptr; out-of-range pointers leave vec intact
    always_comb q = (vec & ~(W'({LANES{1'b1}}) << ptr)) | (W'(ins) << ptr);
  end else begin : g_ext
    logic unused_ins;
    // ins is only meaningful for insertion
    always_comb unused_ins = ^ins;
    // extract the LANES-wide slice starting at ptr
    always_comb q = OW'(vec >> ptr);
  end
endmodule

// File: rtl/spi_shift_reg_ml.sv
// spi_shift_reg_ml: parametrised multi-lane SPI master shift register; optional SPI_SHIFT_LOOPBACK_EN adds mosi->rx loopback
module spi_shift_reg_ml
  import spi_shift_pkg::*;
#(
  parameter int MAX_CHAR = 32,
  parameter int LANES = 1,
  parameter int CHAR_LEN_BITS = $clog2(MAX_CHAR)
) (
  input  logic                     wb_clk_in,
  input  logic                     wb_rst,
  input  logic                     go,
  input  logic [CHAR_LEN_BITS-1:0] len,
  input  logic                     lsb,
  input  logic                     rx_negedge,
  input  logic                     tx_negedge,
  input  logic                     cpol_0,
  input  logic                     cpol_1,
  input  logic [MAX_CHAR/8-1:0]    latch,
  input  logic [MAX_CHAR-1:0]      p_in,
  input  logic [LANES-1:0]         miso,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic                     loopback,
`endif
  output logic [LANES-1:0]         mosi,
  output logic [MAX_CHAR-1:0]      p_out,
  output logic                     tip,
  output logic                     last,
  output logic                     done
);
  localparam int CW = $clog2(MAX_CHAR + 1);
  state_t state, state_nxt;
  logic [MAX_CHAR-1:0] data, rx_data;
  logic [CW-1:0] cnt, l_q, l_nxt, ptr;
  logic lsb_q, tx_edge, rx_edge;
  logic [LANES-1:0] tx_grp, rx_grp;
  if (!lanes_legal(LANES) || MAX_CHAR % 8 != 0 || MAX_CHAR % LANES != 0) begin : g_bad_cfg
    $error("spi_shift_reg_ml: LANES must be 1, 2 or 4 and divide MAX_CHAR, a multiple of 8");
  end
  assign tx_edge = tx_negedge ? cpol_1 : cpol_0;
  assign rx_edge = rx_negedge ? cpol_1 : cpol_0;
  assign l_nxt = CW'(eff_len(int'(len), MAX_CHAR, LANES));
  assign ptr = lsb_q ? l_q - cnt : cnt - CW'(LANES);
  assign p_out = data;
`ifdef SPI_SHIFT_LOOPBACK_EN
  assign rx_grp = loopback ? mosi : miso;
`else
  assign rx_grp = miso;
`endif
  spi_lane_sel #(.W(MAX_CHAR), .LANES(LANES), .PW(CW), .INSERT(1'b0), .OW(LANES)) u_tx (
    .vec(data), .ptr(ptr), .ins('0), .q(tx_grp)
  );
  spi_lane_sel #(.W(MAX_CHAR), .LANES(LANES), .PW(CW), .INSERT(1'b1), .OW(MAX_CHAR)) u_rx (
    .vec(data), .ptr(ptr), .ins(rx_grp), .q(rx_data)
  );
  // state register
  always_ff @(posedge wb_clk_in or posedge wb_rst)
    if (wb_rst) state <= IDLE;
    else state <= state_nxt;
  // leave XFER on the rx strobe that captures the final group
  always_comb state_nxt = state == IDLE ? (go ? XFER : IDLE) : (rx_edge && last ? IDLE : XFER);
  // status and serial outputs; pads idle low outside a transfer
  always_comb begin
    tip = state == XFER;
    last = tip && cnt <= CW'(LANES);
    mosi = tip ? tx_grp : '0;
  end
  // data register, group counter and done pulse
  always_ff @(posedge wb_clk_in or posedge wb_rst)
    if (wb_rst) begin
      data <= '0;
      cnt <= '0;
      l_q <= '0;
      lsb_q <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= tip && rx_edge && last;
      if (!tip) begin
        for (int i = 0; i < MAX_CHAR / 8; i++)
          if (latch[i]) data[8*i +: 8] <= p_in[8*i +: 8];
        if (go) begin
          cnt <= l_nxt;
          l_q <= l_nxt;
          lsb_q <= lsb;
        end
      end else begin
        if (rx_edge) data <= rx_data;
        if (rx_edge && last) cnt <= '0;
        else if (tx_edge && !last) cnt <= cnt - CW'(LANES);
      end
    end
endmodule

// File: tb/tb_spi_shift_reg_ml.sv
// tb_spi_shift_reg_ml: scoreboard bench for the multi-lane SPI shift register (1, 2 and 4 lanes)
module tb_spi_shift_reg_ml;
`ifdef SPI_SHIFT_LOOPBACK_EN
  localparam bit LBK = 1'b1;
`else
  localparam bit LBK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] len = '0;
  logic lsb = 1'b0, rx_neg = 1'b0, tx_neg = 1'b1, c0 = 1'b0, c1 = 1'b0;
  logic [3:0] latch = '0, miso4 = '0;
  logic [31:0] p_in = '0;
  logic [2:0] go_v = '0;
  logic mosi1;
  logic [1:0] mosi2;
  logic [3:0] mosi4;
  logic [31:0] po1, po2, po4;
  logic [2:0] tip_v, last_v, done_v;
  int sel = 0;
  logic [3:0] mosi_s;
  logic [31:0] p_out_s;
  logic tip_s, last_s, done_s;
  logic [31:0] m [3];
  logic [3:0] exp_q [$];
  int checks = 0, errors = 0, done_cnt = 0;

  always #5 clk = ~clk;

  spi_shift_reg_ml #(.MAX_CHAR(32), .LANES(1)) u1 (
    .wb_clk_in(clk), .wb_rst(rst), .go(go_v[0]), .len(len), .lsb(lsb), .rx_negedge(rx_neg),
    .tx_negedge(tx_neg), .cpol_0(c0), .cpol_1(c1), .latch(latch), .p_in(p_in), .miso(miso4[0]),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .mosi(mosi1), .p_out(po1), .tip(tip_v[0]), .last(last_v[0]), .done(done_v[0])
  );
  spi_shift_reg_ml #(.MAX_CHAR(32), .LANES(2)) u2 (
    .wb_clk_in(clk), .wb_rst(rst), .go(go_v[1]), .len(len), .lsb(lsb), .rx_negedge(rx_neg),
    .tx_negedge(tx_neg), .cpol_0(c0), .cpol_1(c1), .latch(latch), .p_in(p_in), .miso(miso4[1:0]),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback(1'b1),
`endif
    .mosi(mosi2), .p_out(po2), .tip(tip_v[1]), .last(last_v[1]), .done(done_v[1])
  );
  spi_shift_reg_ml #(.MAX_CHAR(32), .LANES(4)) u4 (
    .wb_clk_in(clk), .wb_rst(rst), .go(go_v[2]), .len(len), .lsb(lsb), .rx_negedge(rx_neg),
    .tx_negedge(tx_neg), .cpol_0(c0), .cpol_1(c1), .latch(latch), .p_in(p_in), .miso(miso4),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .mosi(mosi4), .p_out(po4), .tip(tip_v[2]), .last(last_v[2]), .done(done_v[2])
  );

  always_comb begin
    mosi_s = sel == 0 ? {3'b0, mosi1} : sel == 1 ? {2'b0, mosi2} : mosi4;
    p_out_s = sel == 0 ? po1 : sel == 1 ? po2 : po4;
    tip_s = tip_v[sel];
    last_s = last_v[sel];
    done_s = done_v[sel];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done_s) done_cnt++;
  endtask

  task automatic strobe(input bit neg, input logic v);
    if (neg) c1 = v;
    else c0 = v;
  endtask

  task automatic load(input logic [31:0] d, input logic [3:0] lt);
    p_in = d;
    latch = lt;
    tick();
    latch = '0;
    for (int k = 0; k < 3; k++)
      for (int b = 0; b < 4; b++)
        if (lt[b]) m[k][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic run(input int s, input int ln, input bit lb, input bit rxn, input bit txn,
                     input logic [31:0] bits, input bit interfere, input int abort_at);
    int lanes, l, n, lo;
    logic [31:0] mm, msk, lmsk, fin;
    lanes = s == 0 ? 1 : s == 1 ? 2 : 4;
    l = ln == 0 ? 32 : ln;
    l = (l + lanes - 1) / lanes * lanes;
    n = l / lanes;
    msk = (32'h1 << lanes) - 1;
    lmsk = l == 32 ? 32'hFFFF_FFFF : (32'h1 << l) - 1;
    mm = m[s];
    fin = (LBK && s == 1) ? mm : (mm & ~lmsk) | (bits & lmsk);
    sel = s; len = 5'(ln); lsb = lb; rx_neg = rxn; tx_neg = txn;
    for (int k = 0; k < n; k++) begin
      lo = lb ? lanes * k : l - lanes * (k + 1);
      exp_q.push_back(4'((mm >> lo) & msk));
    end
    done_cnt = 0;
    go_v[s] = 1'b1;
    tick();
    go_v[s] = 1'b0;
    for (int k = 0; k < n; k++) begin
      lo = lb ? lanes * k : l - lanes * (k + 1);
      check($sformatf("mosi[%0d]", k), 32'(mosi_s), 32'(exp_q.pop_front()));
      check($sformatf("last[%0d]", k), 32'(last_s), 32'(k == n - 1));
      check($sformatf("tip[%0d]", k), 32'(tip_s), 32'd1);
      if (k == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_mosi", 32'(mosi_s), 32'd0);
        check("rst_tip", 32'(tip_s), 32'd0);
        check("rst_last", 32'(last_s), 32'd0);
        check("rst_done", 32'(done_s), 32'd0);
        check("rst_p_out", p_out_s, 32'd0);
        #1 rst = 1'b0;
        for (int j = 0; j < 3; j++) m[j] = '0;
        exp_q.delete();
        repeat (4) tick();
        check("abort_done", 32'(done_cnt), 32'd0);
        check("abort_tip", 32'(tip_s), 32'd0);
        return;
      end
      if (interfere && k == 1) begin
        p_in = 32'hDEAD_BEEF;
        latch = 4'hF;
        go_v[s] = 1'b1;
      end
      miso4 = 4'((bits >> lo) & msk);
      strobe(rxn, 1'b1);
      tick();
      strobe(rxn, 1'b0);
      if (interfere && k == 1) begin
        latch = '0;
        go_v[s] = 1'b0;
        for (int j = 0; j < 3; j++) if (j != s) m[j] = 32'hDEAD_BEEF;
      end
      if (k < n - 1) begin
        if (rxn != txn) begin
          strobe(txn, 1'b1);
          tick();
          strobe(txn, 1'b0);
        end
        tick();
      end
    end
    check("end_tip", 32'(tip_s), 32'd0);
    repeat (3) tick();
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("idle_tip", 32'(tip_s), 32'd0);
    check("p_out", p_out_s, fin);
    m[s] = fin;
  endtask

  initial begin
    for (int j = 0; j < 3; j++) m[j] = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset_tip", 32'(tip_s), 32'd0);
    check("reset_last", 32'(last_s), 32'd0);
    check("reset_done", 32'(done_s), 32'd0);
    check("reset_mosi", 32'(mosi_s), 32'd0);
    check("reset_p_out", p_out_s, 32'd0);
    // 1 lane, MSB first, rx on falling strobe, miso tied high
    load(32'h0000_00A5, 4'b0001);
    run(0, 8, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, -1);
    // 1 lane, LSB first, short character leaves upper bits alone
    load(32'h0000_AA55, 4'b0011);
    run(0, 4, 1'b1, 1'b0, 1'b1, 32'h0000_0005, 1'b0, -1);
    // writes and go during a transfer are ignored
    run(0, 8, 1'b0, 1'b0, 1'b1, 32'h0000_003C, 1'b1, -1);
    // 4 lanes, full width via len=0
    load(32'h1234_5678, 4'hF);
    run(2, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, -1);
    // asynchronous abort after 3 bits, then a clean transfer
    load(32'h0000_00A5, 4'b0001);
    run(0, 8, 1'b0, 1'b0, 1'b1, 32'h0000_00FF, 1'b0, 3);
    load(32'h0000_005A, 4'b0001);
    run(0, 8, 1'b0, 1'b0, 1'b1, 32'h0000_0096, 1'b0, -1);
    // 2 lanes with coinciding rx/tx strobes; loopback builds keep data intact
    load(32'h0000_C3C3, 4'b0011);
    run(1, 16, 1'b0, 1'b0, 1'b0, $urandom, 1'b0, -1);
    // 2 lanes, odd length rounds up to a whole group
    run(1, 3, 1'b1, 1'b1, 1'b1, 32'h0000_0009, 1'b0, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_shift_reg_ml.md
Name: spi_shift_reg_ml

Overview:
Parametrised successor to the SPI master shift register: character width and lane count (1/2/4 bits per SCLK edge) are configurable. Adds a done pulse and strict byte-lane write protection during transfers.
Sits between the Wishbone register file (p_in/p_out, latch) and the SPI pads; the edge strobes come from the SPI clock generator.

Parameters:
MAX_CHAR, 32, maximum character length in bits; a multiple of 8 and of LANES.
LANES, 1, data lanes per direction; legal values 1, 2, 4.
CHAR_LEN_BITS, $clog2(MAX_CHAR), width of len.

Ports:
wb_clk_in  input  1  system clock; all state changes on its rising edge
wb_rst  input  1  asynchronous active-high reset
go  input  1  start request, sampled when tip=0
len  input  CHAR_LEN_BITS  character length; 0 encodes MAX_CHAR
lsb  input  1  1 = LSB first, 0 = MSB first
rx_negedge  input  1  1 = sample on cpol_1 strobe, 0 = sample on cpol_0 strobe
tx_negedge  input  1  1 = launch on cpol_1 strobe, 0 = launch on cpol_0 strobe
cpol_0  input  1  one-cycle strobe marking an SCLK rising edge
cpol_1  input  1  one-cycle strobe marking an SCLK falling edge
latch  input  MAX_CHAR/8  per-byte write enables for p_in
p_in  input  MAX_CHAR  parallel write data
miso  input  LANES  serial input lanes
mosi  output  LANES  serial output lanes
p_out  output  MAX_CHAR  data register contents
tip  output  1  transfer in progress
last  output  1  final launch group in flight
done  output  1  one-cycle pulse at transfer end

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): data=0, cnt=0, tip=0, last=0, done=0, mosi=0. An aborted transfer does not produce done.
- Effective length: L = (len==0 ? MAX_CHAR : len), rounded up to the next multiple of LANES.
- States:
  - IDLE: tip=0. Each latch[i]=1 writes p_in[8i+7:8i] into data.
  - IDLE->XFER: go=1 sets tip=1 and cnt=L on the next cycle. mosi immediately presents the first group.
  - XFER->IDLE: on the rx strobe that captures the final group, tip falls next cycle and done pulses for exactly one cycle.
- Edge selection: tx_edge = tx_negedge ? cpol_1 : cpol_0; rx_edge = rx_negedge ? cpol_1 : cpol_0.
- During XFER:
  - latch and go are ignored.
  - On tx_edge with cnt>LANES: cnt -= LANES and the next group is launched.
- Bit indexing:
  - MSB first: tx group = data[cnt-1 -: LANES]; lane LANES-1 carries the most significant bit.
  - LSB first: tx group = data[L-cnt +: LANES]; lane 0 carries the least significant bit.
  - An rx_edge writes miso into the same index range as the group currently launched.
  - If rx_edge and tx_edge coincide, the capture uses the pre-update pointer.
- last = tip & (cnt<=LANES). The transfer ends on the first rx_edge while last=1.
- Bits of data outside [L-1:0] are unchanged by the transfer.
- p_out = data, combinational.

Optional Feature:
Macro SPI_SHIFT_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When 1, the rx path samples mosi instead of miso, lane for lane; pads are still driven.
- Undefined: no port and no mux; rx always samples miso.

Decomposition:
- Package spi_shift_pkg holds:
  - the lane-count legal set;
  - the state enum IDLE/XFER;
  - a function computing L from len, MAX_CHAR and LANES.
- One sub-module, spi_lane_sel: combinational pointer-to-slice select for tx extraction and rx insertion, instantiated once per direction.

Test Plan:
1. LANES=1, MSB first, len=8, p_in=0x000000A5 (latch=4'b0001), miso tied 1, rx_negedge=1 -> mosi serialises 1,0,1,0,0,1,0,1; p_out=0x000000FF; done pulses once; tip high for 8 SCLK periods.
2. LANES=1, LSB first, len=4, p_in=0xAA55 (latch=4'b0011), miso 1,0,1,0 -> mosi 1,0,1,0; p_out=0x0000AA55 with [3:0] replaced by 4'b0101; bits [31:4] unchanged.
3. LANES=4, MSB first, len=0, p_in=0x12345678 -> 8 tx groups 1,2,…,8; last asserted only during the 8th; miso group 0xF each edge gives p_out=0xFFFFFFFF.
4. During tip, latch=4'b1111 with p_in=0xDEADBEEF and go=1 -> data unaffected except by shifting; no second transfer starts.
5. Assert wb_rst after 3 bits of a len=8 transfer -> all outputs 0 immediately; no done; a following go runs a full clean 8-bit transfer.
6. With SPI_SHIFT_LOOPBACK_EN and loopback=1, LANES=2, len=16, p_in=0xC3C3 -> p_out[15:0]=0xC3C3 regardless of miso.
